// File: rtl/interrupt_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer_pkg
// Shared processor definitions used by the interrupt entry sequencer:
//   - FSM state encoding (IDLE .. SERVICE)
//   - inject_op codes driven towards decode
//   - default interrupt vector
//   - push_word(): selects the 16-bit word pushed for a given inject_op
// ---------------------------------------------------------------------------
package interrupt_sequencer_pkg;

  localparam logic [31:0] IRQ_VECTOR_DEFAULT = 32'h0000_0020;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DRAIN    = 3'd1;
  localparam logic [2:0] ST_PUSH_HI  = 3'd2;
  localparam logic [2:0] ST_PUSH_LO  = 3'd3;
  localparam logic [2:0] ST_PUSH_CCR = 3'd4;
  localparam logic [2:0] ST_VECTOR   = 3'd5;
  localparam logic [2:0] ST_SERVICE  = 3'd6;

  typedef logic [1:0] inject_op_t;

  localparam logic [1:0] OP_PUSH_PC_HI = 2'd0;
  localparam logic [1:0] OP_PUSH_PC_LO = 2'd1;
  localparam logic [1:0] OP_PUSH_CCR   = 2'd2;
  localparam logic [1:0] OP_RESERVED   = 2'd3;

  // Word placed on the stack for each push operation; flags are zero-extended.
  function automatic logic [15:0] push_word(input inject_op_t op,
                                            input logic [31:0] pc,
                                            input logic [2:0]  flags);
    logic [15:0] word;
    case (op)
      OP_PUSH_PC_HI: word = pc[31:16];
      OP_PUSH_PC_LO: word = pc[15:0];
      OP_PUSH_CCR:   word = {13'b0, flags};
      default:       word = 16'h0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_irq_sync.sv
// ---------------------------------------------------------------------------
// irq_sync
// Two-flop synchronizer for the asynchronous interrupt pin followed by a
// rising-edge detector on the synchronized level.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-low reset
//   irq      in   raw interrupt pin (asynchronous to clk)
//   irq_rise out  one-cycle pulse on a 0->1 edge of the synchronized pin
// ---------------------------------------------------------------------------
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic irq_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= irq;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign irq_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer
// Interrupt entry sequencer: on an interrupt it freezes fetch, waits for the
// pipeline to drain, injects three push operations (PC high, PC low, flags)
// into decode, loads the interrupt vector and then reports in-service until
// the handler's RTI retires.
// Ports:
//   clk             in   clock (rising edge)
//   rst             in   synchronous active-low reset
//   irq             in   interrupt pin, asynchronous to clk
//   pc_current[31:0] in  next fetch address (saved on entry)
//   ccr[2:0]        in   condition flags {C,N,Z} (saved on entry)
//   branch_pending  in   control-flow instruction still in flight
//   inject_ready    in   decode accepts the injected operation
//   rti_done        in   RTI writeback pulse
//   freeze_fetch    out  hold PC, feed NOPs into IF/ID
//   inject_valid    out  inject_op / inject_data valid
//   inject_op[1:0]  out  push operation code
//   inject_data[15:0] out word to push
//   pc_load         out  load pc_load_value into the PC
//   pc_load_value[31:0] out interrupt vector
//   in_service      out  handler running
// ---------------------------------------------------------------------------
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] IRQ_VECTOR   = IRQ_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq,
  input  logic [31:0] pc_current,
  input  logic [2:0]  ccr,
  input  logic        branch_pending,
  input  logic        inject_ready,
  input  logic        rti_done,
  output logic        freeze_fetch,
  output logic        inject_valid,
  output logic [1:0]  inject_op,
  output logic [15:0] inject_data,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic        in_service
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);

  logic             w_irq_rise;
  logic             w_start;
  logic             w_drain_done;
  logic             w_push;
  state_t           w_state_next;
  state_t           r_state;
  logic             r_pending;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_saved_pc;
  logic [2:0]       r_saved_ccr;

  irq_sync u_irq_sync (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .irq_rise (w_irq_rise)
  );

  assign w_start = (r_state == ST_IDLE) && r_pending;

  // Leave DRAIN on the same edge that takes the counter to zero, so the
  // freeze lasts exactly DRAIN_CYCLES quiet cycles.
  assign w_drain_done = !branch_pending && (r_cnt <= CNT_W'(1));

  assign w_push = (r_state == ST_PUSH_HI) || (r_state == ST_PUSH_LO) ||
                  (r_state == ST_PUSH_CCR);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (r_pending)    w_state_next = ST_DRAIN;
      ST_DRAIN:    if (w_drain_done) w_state_next = ST_PUSH_HI;
      ST_PUSH_HI:  if (inject_ready) w_state_next = ST_PUSH_LO;
      ST_PUSH_LO:  if (inject_ready) w_state_next = ST_PUSH_CCR;
      ST_PUSH_CCR: if (inject_ready) w_state_next = ST_VECTOR;
      ST_VECTOR:                     w_state_next = ST_SERVICE;
      ST_SERVICE:  if (rti_done)     w_state_next = ST_IDLE;
      default:                       w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pending   <= 1'b0;
      r_cnt       <= '0;
      r_saved_pc  <= '0;
      r_saved_ccr <= '0;
    end else begin
      r_state <= w_state_next;

      // A new edge wins over the clear, so an interrupt arriving on the
      // entry cycle is queued for the next entry rather than dropped.
      if (w_irq_rise) begin
        r_pending <= 1'b1;
      end else if (w_start) begin
        r_pending <= 1'b0;
      end

      if (w_start) begin
        r_cnt       <= CNT_LOAD;
        r_saved_pc  <= pc_current;
        r_saved_ccr <= ccr;
      end else if (r_state == ST_DRAIN) begin
        if (branch_pending) begin
          r_cnt <= CNT_LOAD;
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    inject_op = OP_PUSH_PC_HI;
    case (r_state)
      ST_PUSH_LO:  inject_op = OP_PUSH_PC_LO;
      ST_PUSH_CCR: inject_op = OP_PUSH_CCR;
      default:     inject_op = OP_PUSH_PC_HI;
    endcase
  end

  assign freeze_fetch  = (r_state == ST_DRAIN) || w_push || (r_state == ST_VECTOR);
  assign inject_valid  = w_push;
  assign inject_data   = w_push ? push_word(inject_op, r_saved_pc, r_saved_ccr) : 16'h0000;
  assign pc_load       = (r_state == ST_VECTOR);
  assign in_service    = (r_state == ST_SERVICE);
  assign pc_load_value = IRQ_VECTOR;

endmodule
